// File: rtl/apb_master_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Package     : apb_pkg
// Description : Shared types and constants for the APB master bridge:
//               FSM state encoding, default address map and the slot-index
//               width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam logic [31:0] APB_BASE_DEF  = 32'h1000_0000;
  localparam int          SLOT_LOG2_DEF = 12;

  // Width of a slot index; a single-slot bridge still carries a 1-bit index.
  function automatic int slot_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/apb_master_bridge_if.sv
`default_nettype none
// ============================================================================
// Interface   : apb_master_bridge_if
// Description : CPU-side request/response signals and the APB bus of the
//               bridge. The master modport is the bridge's view; the slave
//               modport is the view of the CPU plus peripherals around it.
// Revision    : 1.0 - initial release
// ============================================================================
interface apb_master_bridge_if #(
  parameter int NUM_SLV = 4
);

  // CPU side
  logic                    transfer;
  logic                    write;
  logic [31:0]             addr;
  logic [31:0]             wdata;
  logic [31:0]             rdata;
  logic                    ready;
  logic                    err;

  // APB side
  logic [31:0]             PADDR;
  logic                    PWRITE;
  logic [31:0]             PWDATA;
  logic                    PENABLE;
  logic [NUM_SLV-1:0]      PSEL;
  logic [NUM_SLV*32-1:0]   PRDATA;
  logic [NUM_SLV-1:0]      PREADY;

  modport master (
    input  transfer, write, addr, wdata, PRDATA, PREADY,
    output rdata, ready, err, PADDR, PWRITE, PWDATA, PENABLE, PSEL
  );

  modport slave (
    output transfer, write, addr, wdata, PRDATA, PREADY,
    input  rdata, ready, err, PADDR, PWRITE, PWDATA, PENABLE, PSEL
  );

endinterface
`default_nettype wire

// File: rtl/apb_master_bridge_addr_decoder.sv
`default_nettype none
// ============================================================================
// Module      : apb_addr_decoder
// Description : Combinational APB slot decoder. Maps a byte address onto a
//               slot index, a hit flag and a one-hot select vector. Addresses
//               below the base or beyond the last slot are misses (no select).
// Revision    : 1.0 - initial release
// ============================================================================
module apb_addr_decoder
  import apb_pkg::*;
#(
  parameter int          NUM_SLV   = 4,
  parameter logic [31:0] APB_BASE  = APB_BASE_DEF,
  parameter int          SLOT_LOG2 = SLOT_LOG2_DEF,
  parameter int          SLOT_W    = slot_w(NUM_SLV)
) (
  input  logic [31:0]        addr,
  output logic [SLOT_W-1:0]  slot,
  output logic               hit,
  output logic [NUM_SLV-1:0] sel
);

  logic [31:0] w_offset;
  logic [31:0] w_slot_full;

  // Unsigned offset from the base; the full-width slot number guards against
  // aliasing of far-away addresses onto a valid slot.
  always_comb begin
    w_offset    = addr - APB_BASE;
    w_slot_full = w_offset >> SLOT_LOG2;
    hit         = (addr >= APB_BASE) && (w_slot_full < 32'(NUM_SLV));
    slot        = w_slot_full[SLOT_W-1:0];
    sel         = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      sel[i] = hit && (w_slot_full == 32'(i));
    end
  end

endmodule
`default_nettype wire

// File: rtl/apb_master_bridge.sv
`default_nettype none
// ============================================================================
// Module      : apb_master_bridge
// Description : Converts a single CPU load/store request into an APB (v3)
//               transfer on one of NUM_SLV slots. Returns read data with a
//               one-cycle ready strobe (err on address miss).
//               Optional macro APB_MASTER_TIMEOUT_EN adds an ACCESS-phase
//               wait limit of TIMEOUT_CYCLES that completes with err.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int          NUM_SLV        = 4,
  parameter logic [31:0] APB_BASE       = APB_BASE_DEF,
  parameter int          SLOT_LOG2      = SLOT_LOG2_DEF,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst,
  apb_master_bridge_if.master bus
);

  localparam int SLOT_W = slot_w(NUM_SLV);

  apb_state_e          r_state;
  apb_state_e          w_next_state;

  logic [SLOT_W-1:0]   w_dec_slot;
  logic                w_dec_hit;
  logic [NUM_SLV-1:0]  w_dec_sel;

  logic [SLOT_W-1:0]   r_slot;
  logic                r_hit;
  logic [NUM_SLV-1:0]  r_psel;
  logic [31:0]         r_paddr;
  logic [31:0]         r_pwdata;
  logic                r_pwrite;

  logic                w_start;
  logic                w_slv_ready;
  logic [31:0]         w_slv_rdata;
  logic                w_timeout;
  logic                w_done;

  apb_addr_decoder #(
    .NUM_SLV   (NUM_SLV),
    .APB_BASE  (APB_BASE),
    .SLOT_LOG2 (SLOT_LOG2),
    .SLOT_W    (SLOT_W)
  ) u_dec (
    .addr (bus.addr),
    .slot (w_dec_slot),
    .hit  (w_dec_hit),
    .sel  (w_dec_sel)
  );

  // Per-slot response of the latched slot; only meaningful on a hit.
  assign w_slv_ready = bus.PREADY[r_slot];
  assign w_slv_rdata = bus.PRDATA[{r_slot, 5'b0} +: 32];
  assign w_start     = (r_state == IDLE) && bus.transfer;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_wait_cnt;

  // Count ACCESS wait cycles of the current transfer; cleared in SETUP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait_cnt <= '0;
    end else if (r_state == SETUP) begin
      r_wait_cnt <= '0;
    end else if ((r_state == ACCESS) && r_hit && !w_slv_ready) begin
      r_wait_cnt <= r_wait_cnt + CNT_W'(1);
    end
  end

  // The wait cycle that would bring the count to the limit ends the transfer.
  assign w_timeout = (r_state == ACCESS) && r_hit && !w_slv_ready &&
                     (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  // ACCESS finishes on a miss, on slave ready, or on the wait limit.
  assign w_done = (r_state == ACCESS) && (!r_hit || w_slv_ready || w_timeout);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state: SETUP always lasts one cycle; ACCESS holds until done.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (bus.transfer) w_next_state = SETUP;
      SETUP:   w_next_state = ACCESS;
      ACCESS:  if (w_done) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Completion outputs; rdata is forced to zero unless a hit read completes.
  always_comb begin
    bus.PENABLE = (r_state == ACCESS);
    bus.ready   = w_done;
    bus.err     = w_done && (!r_hit || w_timeout);
    bus.rdata   = (w_done && r_hit && !r_pwrite && !w_timeout) ? w_slv_rdata : '0;
  end

  // Capture the request at IDLE->SETUP; drop the select after completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_paddr  <= '0;
      r_pwdata <= '0;
      r_pwrite <= 1'b0;
      r_slot   <= '0;
      r_hit    <= 1'b0;
      r_psel   <= '0;
    end else if (w_start) begin
      r_paddr  <= bus.addr;
      r_pwdata <= bus.wdata;
      r_pwrite <= bus.write;
      r_slot   <= w_dec_slot;
      r_hit    <= w_dec_hit;
      r_psel   <= w_dec_sel;
    end else if (w_done) begin
      r_psel   <= '0;
    end
  end

  assign bus.PADDR  = r_paddr;
  assign bus.PWDATA = r_pwdata;
  assign bus.PWRITE = r_pwrite;
  assign bus.PSEL   = r_psel;

endmodule
`default_nettype wire

// File: tb/tb_apb_master_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_master_bridge
// Description : Directed self-checking bench for apb_master_bridge: a table
//               of single transfers plus hand-written busy, back-to-back,
//               reset-abort and wait-limit sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_master_bridge;

  localparam int NS = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  apb_master_bridge_if #(.NUM_SLV(NS)) bus();

  apb_master_bridge #(.NUM_SLV(NS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] prdata;
    logic [3:0]  psel;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Target slot gets the vector's read data; the others carry distinct junk.
  task automatic set_prdata(input logic [3:0] psel, input logic [31:0] val);
    for (int i = 0; i < NS; i++) begin
      bus.PRDATA[32*i +: 32] = psel[i] ? val : (32'hBAD0_0000 | 32'(i));
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, " PSEL"},    32'(bus.PSEL), 32'h0);
    chk({nm, " PENABLE"}, 32'(bus.PENABLE), 32'h0);
    chk({nm, " ready"},   32'(bus.ready), 32'h0);
    chk({nm, " err"},     32'(bus.err), 32'h0);
    chk({nm, " rdata"},   bus.rdata, 32'h0);
    chk({nm, " PADDR"},   bus.PADDR, 32'h0);
    chk({nm, " PWDATA"},  bus.PWDATA, 32'h0);
    chk({nm, " PWRITE"},  32'(bus.PWRITE), 32'h0);
  endtask

  // One transfer from IDLE. With busy set, transfer stays high and addr/write
  // change through SETUP and ACCESS; none of that may leak into the bus.
  task automatic run_txn(input vec_t v, input bit busy, input string nm);
    bit got;
    bus.transfer = 1'b1;
    bus.write    = v.wr;
    bus.addr     = v.addr;
    bus.wdata    = v.wdata;
    bus.PREADY   = '0;
    set_prdata(v.psel, v.prdata);
    tick;
    if (busy) begin
      bus.addr  = 32'h1000_2000;
      bus.write = ~v.wr;
      bus.wdata = 32'h5555_AAAA;
    end else begin
      bus.transfer = 1'b0;
    end
    #1;
    chk({nm, " setup PSEL"},    32'(bus.PSEL), 32'(v.psel));
    chk({nm, " setup PENABLE"}, 32'(bus.PENABLE), 32'h0);
    chk({nm, " setup ready"},   32'(bus.ready), 32'h0);
    got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      tick;
      bus.PREADY = (c >= v.waits) ? v.psel : 4'b0000;
      #1;
      chk({nm, " access PENABLE"}, 32'(bus.PENABLE), 32'h1);
      chk({nm, " access PSEL"},    32'(bus.PSEL), 32'(v.psel));
      chk({nm, " access PADDR"},   bus.PADDR, v.addr);
      chk({nm, " access PWRITE"},  32'(bus.PWRITE), 32'(v.wr));
      if (bus.ready) begin
        got = 1'b1;
        chk({nm, " ready cycle"}, 32'(c), 32'(v.waits));
        chk({nm, " err"},         32'(bus.err), 32'(v.err));
        chk({nm, " rdata"},       bus.rdata, v.rdata);
        if (v.wr) chk({nm, " PWDATA"}, bus.PWDATA, v.wdata);
      end else begin
        chk({nm, " wait rdata"}, bus.rdata, 32'h0);
      end
    end
    if (!got) chk({nm, " ready seen"}, 32'h0, 32'h1);
    tick;
    bus.transfer = 1'b0;
    bus.PREADY   = '0;
    #1;
    chk({nm, " post PSEL"},    32'(bus.PSEL), 32'h0);
    chk({nm, " post PENABLE"}, 32'(bus.PENABLE), 32'h0);
    chk({nm, " post ready"},   32'(bus.ready), 32'h0);
    if (busy) begin
      tick;
      #1;
      chk({nm, " no extra PSEL"},    32'(bus.PSEL), 32'h0);
      chk({nm, " no extra PENABLE"}, 32'(bus.PENABLE), 32'h0);
    end
  endtask

  vec_t tv;

  initial begin
    //            wr    addr          wdata         w  prdata        psel     err   rdata
    vecs[0] = '{1'b1, 32'h1000_1004, 32'hDEAD_BEEF, 0, 32'h0,        4'b0010, 1'b0, 32'h0};
    vecs[1] = '{1'b0, 32'h1000_3000, 32'h0,         3, 32'h1234_5678, 4'b1000, 1'b0, 32'h1234_5678};
    vecs[2] = '{1'b0, 32'h2000_0000, 32'h0,         0, 32'h0,        4'b0000, 1'b1, 32'h0};
    vecs[3] = '{1'b0, 32'h1000_0000, 32'h0,         1, 32'hA5A5_0001, 4'b0001, 1'b0, 32'hA5A5_0001};
    vecs[4] = '{1'b0, 32'h1000_3FFC, 32'h0,         0, 32'hCAFE_F00D, 4'b1000, 1'b0, 32'hCAFE_F00D};
    vecs[5] = '{1'b0, 32'h1000_4000, 32'h0,         0, 32'h0,        4'b0000, 1'b1, 32'h0};
    vecs[6] = '{1'b1, 32'h0FFF_FFFC, 32'h1357_9BDF, 0, 32'h0,        4'b0000, 1'b1, 32'h0};
    vecs[7] = '{1'b1, 32'h1000_2ABC, 32'h0123_4567, 2, 32'h0,        4'b0100, 1'b0, 32'h0};
    vecs[8] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         0, 32'h0,        4'b0000, 1'b1, 32'h0};
    vecs[9] = '{1'b0, 32'h1000_2008, 32'h0,         0, 32'h0BAD_CAFE, 4'b0100, 1'b0, 32'h0BAD_CAFE};

    bus.transfer = 1'b0;
    bus.write    = 1'b0;
    bus.addr     = '0;
    bus.wdata    = '0;
    bus.PREADY   = '0;
    bus.PRDATA   = '0;

    // Reset state
    #2;
    chk_all_zero("reset");
    tick;
    tick;
    @(negedge clk);
    rst = 1'b0;
    tick;
    #1;

    // Table of single transfers
    for (int i = 0; i < 10; i++) begin
      run_txn(vecs[i], 1'b0, $sformatf("vec%0d", i));
    end

    // transfer pulsed through SETUP and ACCESS of a waiting read
    tv = '{1'b0, 32'h1000_1010, 32'h0, 2, 32'h6666_1111, 4'b0010, 1'b0, 32'h6666_1111};
    run_txn(tv, 1'b1, "busy");

    // Back-to-back: transfer held high across ready
    bus.transfer = 1'b1;
    bus.write    = 1'b1;
    bus.addr     = 32'h1000_0010;
    bus.wdata    = 32'h1111_2222;
    bus.PREADY   = 4'b0001;
    tick; #1;
    chk("b2b setup1 PSEL", 32'(bus.PSEL), 32'h1);
    tick; #1;
    chk("b2b access1 ready", 32'(bus.ready), 32'h1);
    tick; #1;
    chk("b2b idle ready", 32'(bus.ready), 32'h0);
    chk("b2b idle PSEL",  32'(bus.PSEL), 32'h0);
    tick;
    bus.transfer = 1'b0;
    #1;
    chk("b2b setup2 PSEL",    32'(bus.PSEL), 32'h1);
    chk("b2b setup2 PENABLE", 32'(bus.PENABLE), 32'h0);
    tick; #1;
    chk("b2b access2 ready", 32'(bus.ready), 32'h1);
    tick;
    bus.PREADY = '0;
    #1;
    chk("b2b end PSEL", 32'(bus.PSEL), 32'h0);
    tick; #1;
    chk("b2b no third PSEL", 32'(bus.PSEL), 32'h0);

    // Asynchronous reset while ACCESS waits
    bus.transfer = 1'b1;
    bus.write    = 1'b1;
    bus.addr     = 32'h1000_2010;
    bus.wdata    = 32'hA5A5_5A5A;
    bus.PREADY   = '0;
    tick;
    bus.transfer = 1'b0;
    tick; #1;
    chk("rst pre PENABLE", 32'(bus.PENABLE), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("rst mid");
    bus.PREADY = 4'b0100;
    tick; #1;
    chk("rst held ready", 32'(bus.ready), 32'h0);
    @(negedge clk);
    rst        = 1'b0;
    bus.PREADY = '0;
    tick; #1;
    chk("rst after ready", 32'(bus.ready), 32'h0);
    tv = '{1'b0, 32'h1000_2010, 32'h0, 0, 32'h7777_8888, 4'b0100, 1'b0, 32'h7777_8888};
    run_txn(tv, 1'b0, "after rst");

`ifdef APB_MASTER_TIMEOUT_EN
    // Slave never responds: the 16th wait cycle completes with err
    begin
      bit got;
      bus.transfer = 1'b1;
      bus.write    = 1'b0;
      bus.addr     = 32'h1000_0000;
      bus.PREADY   = '0;
      set_prdata(4'b0001, 32'h9999_0000);
      tick;
      bus.transfer = 1'b0;
      got = 1'b0;
      for (int c = 0; c < 40 && !got; c++) begin
        tick; #1;
        if (bus.ready) begin
          got = 1'b1;
          chk("tmo cycle", 32'(c), 32'd15);
          chk("tmo err",   32'(bus.err), 32'h1);
          chk("tmo rdata", bus.rdata, 32'h0);
        end
      end
      if (!got) chk("tmo ready seen", 32'h0, 32'h1);
      tick;
      bus.PREADY = 4'b0001;
      #1;
      chk("tmo late ready", 32'(bus.ready), 32'h0);
      tick; #1;
      chk("tmo late ready2", 32'(bus.ready), 32'h0);
      chk("tmo late PSEL",   32'(bus.PSEL), 32'h0);
      bus.PREADY = '0;
    end
`else
    // Without the wait limit a long wait still completes normally
    tv = '{1'b0, 32'h1000_0020, 32'h0, 20, 32'h4242_4242, 4'b0001, 1'b0, 32'h4242_4242};
    run_txn(tv, 1'b0, "long wait");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Hard stop in case the main sequence stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
